dst_reg_pipe: RTL



---
 rtl/mips_pipe_pkg.sv | 28 ++
 rtl/dst_match_prio.sv | 56 +++++
 rtl/dst_reg_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
// Shared constants for the MIPS pipeline helpers: destination-select
// encodings, instruction field positions, the zero register number and
// the indices of the tracked stages after ID.
package mips_pipe_pkg;

    // Destination-register select modes driven by the decoder
    typedef enum logic [1:0] {
        DST_RD   = 2'd0,
        DST_RT   = 2'd1,
        DST_LINK = 2'd2,
        DST_NONE = 2'd3
    } dst_sel_e;

    // Least-significant bit of each register field in the instruction word
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

    // Register 0 is hard-wired to zero and never tracked as a destination
    localparam int REG_ZERO = 0;

    // Stage indices of the tracked pipeline stages after ID
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

endpackage : mips_pipe_pkg

// File: rtl/dst_match_prio.sv
// dst_match_prio
// Compares one ID-stage source register against every in-flight
// destination and picks the youngest (lowest-index) stage that hits.
// Ports:
//   i_en      enable; no hits are reported when low
//   i_src     source register number from ID
//   i_stg_dst packed stage destinations, stage k at [k*RADDR_W +: RADDR_W]
//   i_stg_vld per-stage write-valid bits
//   o_hit     per-stage hit vector
//   o_fwd     youngest hitting stage index + 1, 0 when no stage hits
module dst_match_prio
    import mips_pipe_pkg::*;
#(
    parameter int RADDR_W    = 5,
    parameter int NUM_STAGES = 3
) (
    input  logic                          i_en,
    input  logic [RADDR_W-1:0]            i_src,
    input  logic [NUM_STAGES*RADDR_W-1:0] i_stg_dst,
    input  logic [NUM_STAGES-1:0]         i_stg_vld,
    output logic [NUM_STAGES-1:0]         o_hit,
    output logic [3:0]                    o_fwd
);

    logic [NUM_STAGES-1:0] w_hit;
    logic [3:0]            w_fwd;

    // Per-stage equality against valid destinations
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (i_en && i_stg_vld[k] && (i_stg_dst[k*RADDR_W +: RADDR_W] == i_src)) begin
                w_hit[k] = 1'b1;
            end else begin
                w_hit[k] = 1'b0;
            end
        end
    end

    // Priority encode: scanning from the oldest stage down lets the
    // youngest hit overwrite any older one
    always_comb begin
        w_fwd = 4'd0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_fwd = 4'(k + 1);
            end else begin
                w_fwd = w_fwd;
            end
        end
    end

    assign o_hit = w_hit;
    assign o_fwd = w_fwd;

endmodule : dst_match_prio

// File: rtl/dst_reg_pipe.sv
// dst_reg_pipe
// Decodes the destination register of the ID-stage instruction, tracks it
// (with valid and load flags) through NUM_STAGES downstream stages and
// reports source/destination hits, forward selects and load-use stalls.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   ifid_out        instruction word at IF/ID
//   id_valid        ID holds a real instruction
//   dst_sel         destination mode: rd, rt, link register, none
//   mem_read        ID instruction is a load
//   stall, flush    bubble requests for stage 0 (EX)
//   id_dst          combinational decoded destination
//   stg_dst,stg_vld registered per-stage destination and valid bit
//   rs_hit,rt_hit   per-stage source hits
//   rs_fwd,rt_fwd   youngest hitting stage + 1, 0 = none
//   load_use        load-use stall request
module dst_reg_pipe
    import mips_pipe_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int RADDR_W    = 5,
    parameter int NUM_STAGES = 3,
    parameter int LINK_REG   = 31
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [INSTR_W-1:0]            ifid_out,
    input  logic                          id_valid,
    input  logic [1:0]                    dst_sel,
    input  logic                          mem_read,
    input  logic                          stall,
    input  logic                          flush,
    output logic [RADDR_W-1:0]            id_dst,
    output logic [NUM_STAGES*RADDR_W-1:0] stg_dst,
    output logic [NUM_STAGES-1:0]         stg_vld,
    output logic [NUM_STAGES-1:0]         rs_hit,
    output logic [NUM_STAGES-1:0]         rt_hit,
    output logic [3:0]                    rs_fwd,
    output logic [3:0]                    rt_fwd,
    output logic                          load_use
);

    logic [RADDR_W-1:0]    w_rs;
    logic [RADDR_W-1:0]    w_rt;
    logic [RADDR_W-1:0]    w_rd;
    logic [RADDR_W-1:0]    w_id_dst;
    logic                  w_id_wr;
    logic                  w_bubble;
    logic                  w_unused_bits;
    logic                  w_unused_ld;

    logic [RADDR_W-1:0]    r_dst [NUM_STAGES];
    logic [NUM_STAGES-1:0] r_vld;
    logic [NUM_STAGES-1:0] r_ld;

    logic [NUM_STAGES*RADDR_W-1:0] w_stg_dst;
    logic [NUM_STAGES-1:0]         w_rs_hit;
    logic [NUM_STAGES-1:0]         w_rt_hit;
    logic [3:0]                    w_rs_fwd;
    logic [3:0]                    w_rt_fwd;

    assign w_rs = ifid_out[RS_LSB +: RADDR_W];
    assign w_rt = ifid_out[RT_LSB +: RADDR_W];
    assign w_rd = ifid_out[RD_LSB +: RADDR_W];

    // Opcode/funct bits play no part in destination tracking
    assign w_unused_bits = ^{ifid_out[INSTR_W-1:RS_LSB+RADDR_W], ifid_out[RD_LSB-1:0]};

    // Destination decode from the select mode
    always_comb begin
        w_id_dst = '0;
        case (dst_sel)
            DST_RD:   w_id_dst = w_rd;
            DST_RT:   w_id_dst = w_rt;
            DST_LINK: w_id_dst = RADDR_W'(LINK_REG);
            DST_NONE: w_id_dst = '0;
            default:  w_id_dst = '0;
        endcase
    end

    // Writes to r0 are dropped so they can never cause a false hit
    assign w_id_wr  = id_valid && (dst_sel != DST_NONE) && (w_id_dst != RADDR_W'(REG_ZERO));
    assign w_bubble = stall || flush;

    // Stage registers: stage 0 captures ID or a bubble, the rest shift on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_dst[k] <= '0;
            end
            r_vld <= '0;
            r_ld  <= '0;
        end else begin
            if (w_bubble) begin
                r_dst[STG_EX] <= '0;
                r_vld[STG_EX] <= 1'b0;
                r_ld[STG_EX]  <= 1'b0;
            end else begin
                r_dst[STG_EX] <= w_id_dst;
                r_vld[STG_EX] <= w_id_wr;
                r_ld[STG_EX]  <= mem_read && w_id_wr;
            end
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_dst[k] <= r_dst[k-1];
                r_vld[k] <= r_vld[k-1];
                r_ld[k]  <= r_ld[k-1];
            end
        end
    end

    // Only the EX load flag drives a stall; older copies just ride along
    assign w_unused_ld = ^r_ld[NUM_STAGES-1:1];

    // Pack the per-stage destinations into the flat output bus
    always_comb begin
        w_stg_dst = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_stg_dst[k*RADDR_W +: RADDR_W] = r_dst[k];
        end
    end

    dst_match_prio #(
        .RADDR_W    (RADDR_W),
        .NUM_STAGES (NUM_STAGES)
    ) u_rs_match (
        .i_en      (id_valid),
        .i_src     (w_rs),
        .i_stg_dst (w_stg_dst),
        .i_stg_vld (r_vld),
        .o_hit     (w_rs_hit),
        .o_fwd     (w_rs_fwd)
    );

    dst_match_prio #(
        .RADDR_W    (RADDR_W),
        .NUM_STAGES (NUM_STAGES)
    ) u_rt_match (
        .i_en      (id_valid),
        .i_src     (w_rt),
        .i_stg_dst (w_stg_dst),
        .i_stg_vld (r_vld),
        .o_hit     (w_rt_hit),
        .o_fwd     (w_rt_fwd)
    );

    assign id_dst   = w_id_dst;
    assign stg_dst  = w_stg_dst;
    assign stg_vld  = r_vld;
    assign rs_hit   = w_rs_hit;
    assign rt_hit   = w_rt_hit;
    assign rs_fwd   = w_rs_fwd;
    assign rt_fwd   = w_rt_fwd;
    // An rt-destination instruction does not read rt, so its rt match is ignored
    assign load_use = id_valid && r_ld[STG_EX]
                      && (w_rs_hit[STG_EX] || (w_rt_hit[STG_EX] && (dst_sel != DST_RT)));

endmodule : dst_reg_pipe
